// File: rtl/cfm_poller_pkg.sv
// Shared types and constants for the CFM-side RS485 poller and the LCB answer logic.
package cfm_poller_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGuardPre,
        StSend,
        StGuardPost,
        StWaitResp,
        StRecv,
        StDone,
        StErr
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RESP_TO = 2'b01;
    localparam logic [1:0] ERR_BYTE_TO = 2'b10;
    localparam logic [1:0] ERR_FRAME   = 2'b11;

    localparam int unsigned FRAME_LEN_MAX = 32;
    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned TIMER_W       = 16;

endpackage

// File: rtl/cfm_poller_if.sv
// Host-side control, status and buffer read port of the poller.
interface cfm_poller_if;
    import cfm_poller_pkg::*;

    logic              start;
    logic [7:0]        req_byte;
    logic              busy;
    logic              frame_done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] rx_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (
        output start, req_byte, rd_addr,
        input  busy, frame_done, err, err_code, rx_count, rd_data
    );

    modport slave (
        input  start, req_byte, rd_addr,
        output busy, frame_done, err, err_code, rx_count, rd_data
    );

endinterface

// File: rtl/cfm_uart_rx.sv
// 8N1 deserializer: synchronised RX, start bit re-checked at half bit, centre sampling.
module cfm_uart_rx #(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFerr
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

    rx_state_t        state_q;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RxIdle;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            oData   <= '0;
            oValid  <= 1'b0;
            oFerr   <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            oValid  <= 1'b0;
            oFerr   <= 1'b0;
            unique case (state_q)
                RxIdle: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RxStart;
                        cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (cnt_q == HALF_LAST) begin
                        // A high line at mid start bit was a glitch, not a frame.
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= RxStop;
                        else bit_q <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt_q == BIT_LAST) begin
                        oData   <= shift_q;
                        oValid  <= sync2_q;
                        oFerr   <= !sync2_q;
                        state_q <= RxIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/cfm_poller.sv
// RS485 poll master: sends one request byte, turns the bus around and buffers the answer frame.
module cfm_poller
    import cfm_poller_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = 16,
    parameter int unsigned FRAME_LEN    = 32,
    parameter int unsigned GUARD_BITS   = 2,
    parameter int unsigned RESP_TIMEOUT = 4096,
    parameter int unsigned BYTE_TIMEOUT = 640
) (
    input  logic         clk,
    input  logic         rst,
    cfm_poller_if.slave  host,
    input  logic         RX,
    output logic         TX,
    output logic         dirTX,
    output logic         dirRX
);

    localparam logic [TIMER_W-1:0] GUARD_LAST = TIMER_W'(GUARD_BITS * BAUD_DIV - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(BAUD_DIV - 1);
    localparam logic [TIMER_W-1:0] RESP_LAST  = TIMER_W'(RESP_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BYTE_LAST  = TIMER_W'(BYTE_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(FRAME_LEN - 1);

    state_t             state_q;
    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] timer_q;
    logic [3:0]         bit_q;
    logic [9:0]         frame_q;
    logic               tx_q, dir_q, busy_q, done_q, err_q;
    logic [1:0]         code_q;
    logic [ADDR_W-1:0]  count_q;
    logic [7:0]         buffer_q [2**ADDR_W];
    logic [7:0]         rd_data_q;

    logic       rx_rst, rx_valid, rx_ferr, buf_we;
    logic [7:0] rx_data;

    // Receiver is deaf while we drive the bus, so our own echo is never seen.
    assign rx_rst = rst | dir_q;

    cfm_uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk   (clk),
        .rst   (rx_rst),
        .rx    (RX),
        .oData (rx_data),
        .oValid(rx_valid),
        .oFerr (rx_ferr)
    );

    assign buf_we = rx_valid && (state_q == StWaitResp || state_q == StRecv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            timer_q <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            tx_q    <= 1'b1;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (host.start) begin
                        frame_q <= {1'b1, host.req_byte, 1'b0};
                        count_q <= '0;
                        code_q  <= ERR_NONE;
                        busy_q  <= 1'b1;
                        dir_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StGuardPre;
                    end
                end
                StGuardPre: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= frame_q[0];
                        state_q <= StSend;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSend: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 4'd9) begin
                            tx_q    <= 1'b1;
                            state_q <= StGuardPost;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= frame_q[1];
                            frame_q <= {1'b1, frame_q[9:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGuardPost: begin
                    if (cnt_q == GUARD_LAST) begin
                        dir_q   <= 1'b0;
                        timer_q <= '0;
                        state_q <= StWaitResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitResp, StRecv: begin
                    if (rx_ferr) begin
                        code_q  <= ERR_FRAME;
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end else if (rx_valid) begin
                        count_q <= count_q + 1'b1;
                        timer_q <= '0;
                        if (count_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StRecv;
                        end
                    end else if (timer_q == ((state_q == StWaitResp) ? RESP_LAST : BYTE_LAST)) begin
                        code_q  <= (state_q == StWaitResp) ? ERR_RESP_TO : ERR_BYTE_TO;
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDone, StErr: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) buffer_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            if (buf_we) buffer_q[count_q] <= rx_data;
            rd_data_q <= buffer_q[host.rd_addr];
        end
    end

    assign TX              = tx_q;
    assign dirTX           = dir_q;
    assign dirRX           = dir_q;
    assign host.busy       = busy_q;
    assign host.frame_done = done_q;
    assign host.err        = err_q;
    assign host.err_code   = code_q;
    assign host.rx_count   = count_q;
    assign host.rd_data    = rd_data_q;

endmodule

// File: tb/tb_cfm_poller.sv
// Directed bench for cfm_poller: request serialisation, frame capture, timeouts, framing, reset.
module tb_cfm_poller;
    import cfm_poller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    logic tx, dir_tx, dir_rx;

    cfm_poller_if host();

    cfm_poller dut (
        .clk  (clk),
        .rst  (rst),
        .host (host),
        .RX   (rx_line),
        .TX   (tx),
        .dirTX(dir_tx),
        .dirRX(dir_rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int poll_cnt = 0;
    logic dir_prev = 1'b0;

    always @(negedge clk) begin
        if (host.frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (host.err === 1'b1) err_cnt <= err_cnt + 1;
        if (dir_tx === 1'b1 && dir_prev === 1'b0) poll_cnt <= poll_cnt + 1;
        dir_prev <= dir_tx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d);
        rx_line = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            tick(16);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bits(d);
        rx_line = stop;
        tick(16);
        rx_line = 1'b1;
    endtask

    task automatic poll(input logic [7:0] req);
        host.req_byte = req;
        host.start = 1'b1;
        tick(1);
        host.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_bits;
        int d0, e0, p0;
        exp_bits = 10'b1101001010;
        host.start = 1'b0;
        host.req_byte = 8'h00;
        host.rd_addr = '0;

        // Reset state
        tick(2);
        check("rst_tx", tx, 1);
        check("rst_dirtx", dir_tx, 0);
        check("rst_dirrx", dir_rx, 0);
        check("rst_busy", host.busy, 0);
        check("rst_done", host.frame_done, 0);
        check("rst_err", host.err, 0);
        check("rst_code", host.err_code, 0);
        check("rst_count", host.rx_count, 0);
        check("rst_rd", host.rd_data, 0);
        rst = 1'b0;
        tick(2);

        // Request 0xA5: guard, 10 bits, guard, turnaround
        poll(8'hA5);
        check("a5_dir_rise", dir_tx, 1);
        check("a5_busy", host.busy, 1);
        check("a5_tx_idle", tx, 1);
        tick(31);
        check("a5_guard_end", tx, 1);
        tick(1);
        check("a5_start_edge", tx, 0);
        for (int b = 0; b < 10; b++) begin
            tick(8);
            check($sformatf("a5_bit%0d", b), tx, exp_bits[b]);
            check($sformatf("a5_dir%0d", b), dir_tx, 1);
            tick(8);
        end
        check("a5_post_tx", tx, 1);
        tick(31);
        check("a5_post_dir", dir_tx, 1);
        tick(1);
        check("a5_dir_fall", dir_tx, 0);
        check("a5_dirrx_fall", dir_rx, 0);

        // Full 32-byte answer 0x00..0x1F
        tick(10);
        for (int i = 0; i < 32; i++) send_byte(i[7:0], 1'b1);
        tick(20);
        check("frame_done_cnt", done_cnt, 1);
        check("frame_err_cnt", err_cnt, 0);
        check("frame_count", host.rx_count, 0);
        check("frame_busy", host.busy, 0);
        check("frame_code", host.err_code, ERR_NONE);
        for (int a = 0; a < 32; a++) begin
            host.rd_addr = a[4:0];
            tick(1);
            check($sformatf("rd%0d", a), host.rd_data, a);
        end

        // No answer: response timeout exactly 4096 clocks after turnaround
        poll(8'h3C);
        tick(223);
        check("to_dir_pre", dir_tx, 1);
        tick(1);
        check("to_dir_fall", dir_tx, 0);
        tick(4095);
        check("to_err_early", host.err, 0);
        check("to_busy_early", host.busy, 1);
        tick(1);
        check("to_err", host.err, 1);
        check("to_code", host.err_code, ERR_RESP_TO);
        tick(1);
        check("to_err_end", host.err, 0);
        check("to_busy_end", host.busy, 0);
        check("to_code_hold", host.err_code, ERR_RESP_TO);

        // Responder stops after 10 bytes: byte timeout
        e0 = err_cnt;
        poll(8'h11);
        tick(234);
        for (int i = 0; i < 10; i++) send_byte(8'h80 + i[7:0], 1'b1);
        for (int i = 0; i < 800 && err_cnt == e0; i++) tick(1);
        tick(2);
        check("bto_err_cnt", err_cnt, e0 + 1);
        check("bto_code", host.err_code, ERR_BYTE_TO);
        check("bto_count", host.rx_count, 10);
        check("bto_busy", host.busy, 0);
        check("bto_done_cnt", done_cnt, 1);
        host.rd_addr = 5'd9;
        tick(1);
        check("bto_rd9", host.rd_data, 8'h89);
        host.rd_addr = 5'd10;
        tick(1);
        check("bto_rd10_stale", host.rd_data, 8'h0A);

        // Byte 3 with stop bit 0: framing error, bad byte not stored
        e0 = err_cnt;
        poll(8'h22);
        tick(234);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h44, 1'b0);
        tick(5);
        check("fe_err_cnt", err_cnt, e0 + 1);
        check("fe_code", host.err_code, ERR_FRAME);
        check("fe_count", host.rx_count, 3);
        host.rd_addr = 5'd2;
        tick(1);
        check("fe_rd2", host.rd_data, 8'h43);
        host.rd_addr = 5'd3;
        tick(1);
        check("fe_rd3_kept", host.rd_data, 8'h83);

        // start held high: one poll per IDLE visit, then reset mid-SEND
        p0 = poll_cnt;
        e0 = err_cnt;
        d0 = done_cnt;
        host.req_byte = 8'h5A;
        host.start = 1'b1;
        tick(1);
        check("hold_busy", host.busy, 1);
        tick(233);
        send_bits(8'hFF);
        rx_line = 1'b0;
        for (int i = 0; i < 40 && host.err !== 1'b1; i++) tick(1);
        rx_line = 1'b1;
        check("hold_err", host.err, 1);
        check("hold_err_code", host.err_code, ERR_FRAME);
        check("hold_one_poll", poll_cnt, p0 + 1);
        check("hold_busy_err", host.busy, 1);
        tick(1);
        check("hold_idle_busy", host.busy, 0);
        check("hold_idle_dir", dir_tx, 0);
        tick(1);
        check("hold_repoll_busy", host.busy, 1);
        check("hold_repoll_dir", dir_tx, 1);
        check("hold_repoll_code", host.err_code, ERR_NONE);
        tick(40);
        check("hold_send_tx", tx, 0);
        check("hold_two_polls", poll_cnt, p0 + 2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_tx", tx, 1);
        check("arst_dirtx", dir_tx, 0);
        check("arst_dirrx", dir_rx, 0);
        check("arst_busy", host.busy, 0);
        tick(3);
        check("arst_busy_hold", host.busy, 0);
        check("arst_no_done", done_cnt, d0);
        check("arst_no_err", err_cnt, e0 + 1);
        check("arst_rd_clear", host.rd_data, 0);
        host.start = 1'b0;
        rst = 1'b0;
        tick(3);
        check("post_rst_busy", host.busy, 0);
        check("post_rst_dir", dir_tx, 0);
        check("post_rst_polls", poll_cnt, p0 + 2);
        check("post_rst_code", host.err_code, ERR_NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
